// File: rtl/piso_tx_sched_if.sv
// Request/word bundle and serial output of the shared PISO scheduler.
// master = producers and serial consumer side, slave = scheduler.
interface piso_tx_sched_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         sel_id;
    logic                  sout;
    logic                  sout_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output req, din,
        input  gnt, sel_id, sout, sout_valid, busy, done
    );

    modport slave (
        input  req, din,
        output gnt, sel_id, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_tx_sched.sv
// Round-robin arbiter feeding one shared MSB-first shift register,
// with a programmable idle gap after every frame.
//
// state   | meaning
// S_IDLE  | waiting for a request; arbitration happens on the edge leaving
// S_SHIFT | frame bits on sout, sout_valid high, WIDTH cycles
// S_GAP   | GAP idle cycles after a frame, busy still high
module piso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int GAP   = 1
) (
    input  logic            clk,
    input  logic            rst,
    piso_tx_sched_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shreg, shreg_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [GW-1:0]     gcnt, gcnt_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [NREQ-1:0]   gnt_q, gnt_nxt;
    logic [IW-1:0]     sel_q, sel_nxt;
    logic              sout_q, sout_nxt;
    logic              sv_q, sv_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    logic              found;
    logic [IW-1:0]     win;
    logic [IW-1:0]     cand;
    logic [WIDTH-1:0]  word;

    // First pending request at or after ptr, wrapping past the last index.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            gcnt   <= '0;
            ptr    <= '0;
            gnt_q  <= '0;
            sel_q  <= '0;
            sout_q <= 1'b0;
            sv_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            gcnt   <= gcnt_nxt;
            ptr    <= ptr_nxt;
            gnt_q  <= gnt_nxt;
            sel_q  <= sel_nxt;
            sout_q <= sout_nxt;
            sv_q   <= sv_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Outputs are registered, so each branch computes the values for the
    // cycle after the edge, e.g. sout gets the bit that will be MSB next.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        sel_nxt   = sel_q;
        sout_nxt  = 1'b0;
        sv_nxt    = 1'b0;
        done_nxt  = 1'b0;
        word      = bus.din[win*WIDTH +: WIDTH];
        case (state)
            S_IDLE: begin
                if (found) begin
                    shreg_nxt = word;
                    sout_nxt  = word[WIDTH-1];
                    sv_nxt    = 1'b1;
                    gnt_nxt   = NREQ'(1) << win;
                    sel_nxt   = win;
                    ptr_nxt   = (win == LAST_ID) ? '0 : win + 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_nxt = shreg << 1;
                if (cnt == '0) begin
                    done_nxt = 1'b1;
                    if (GAP > 0) begin
                        gcnt_nxt  = GAP_LOAD;
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    sout_nxt = shreg_nxt[WIDTH-1];
                    sv_nxt   = 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gcnt_nxt = gcnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel_id     = sel_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sv_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
Round-robin scheduler that shares one parallel-in/serial-out shifter between NREQ requesters. It arbitrates among pending requests and loads the winner's parallel word. The word is shifted out MSB-first with a valid qualifier, followed by a configurable idle gap. The block sits between several parallel producers and a single serial output line, and owns the shift register's load/shift sequencing.

Parameters:
WIDTH, 4, bits per parallel word / serial frame length
NREQ, 4, number of requesters (>=2)
GAP, 1, extra idle cycles inserted after each frame (>=0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request; bit i = requester i has a word pending
din  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot, registered, high one cycle when requester i's word is captured
sel_id  output  clog2(NREQ)  index of requester whose frame is on sout, held until next grant
sout  output  1  serial data, MSB first
sout_valid  output  1  high on every cycle sout carries a frame bit
busy  output  1  high in SHIFT and GAP states
done  output  1  one-cycle pulse in the cycle after a frame's last bit

Behaviour:
- Reset (async, immediate): state=IDLE; shreg=0; bit counter=0; RR pointer=0; gap counter=0. Outputs gnt=0, sel_id=0, sout=0, sout_valid=0, busy=0, done=0.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE: at a rising edge with req!=0, select the first set req bit searching from index ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - On that edge: shreg<=din[winner], gnt<=onehot(winner), sel_id<=winner, ptr<=(winner+1) mod NREQ, cnt<=WIDTH-1, state->SHIFT.
  - With req==0 the block stays in IDLE with all outputs low; sel_id is held.
- SHIFT: sout=shreg[WIDTH-1] and sout_valid=1 every cycle, busy=1, gnt drops after the first SHIFT cycle.
  - Each edge: shreg shifts left, 0 fills the LSB, cnt decrements. The frame lasts exactly WIDTH cycles.
  - At the edge where cnt==0: done<=1 for one cycle, sout<=0, sout_valid<=0. State->GAP with gap counter=GAP-1 if GAP>0, else state->IDLE.
- GAP: busy=1, sout=0, sout_valid=0 for GAP cycles, then IDLE.
- Inter-frame spacing: minimum GAP+1 cycles with sout_valid=0 between frames, because arbitration happens on the edge leaving IDLE.
- Grant latency: a request sampled at edge k in IDLE gives gnt=1 and the first data bit in the cycle following edge k.
- Request rules:
  - req is ignored outside IDLE; a pending request waits and is never lost while held.
  - Requesters hold req and din until gnt; din is sampled only at the grant edge.
  - A req deasserted before grant is not served. The RR pointer advances only on a grant.
- Fairness: with all req held high, grants cycle 0,1,2,...,NREQ-1,0 and no requester waits more than NREQ-1 frames.
- Reset mid-frame: the frame is aborted immediately; sout_valid and sout fall, no done pulse, and the pointer returns to 0.
- Simultaneous events: req changing on the done edge has no effect until the IDLE edge. A rst pulse overrides everything.

Test Plan:
- Single requester (WIDTH=4, NREQ=4, GAP=1): rst high 5ns, then req=4'b0001, din[3:0]=4'b1011 -> gnt=0001 one cycle; sout=1,0,1,1 over 4 valid cycles; done pulse; busy low 2 cycles after the last bit; sel_id=0.
- Full contention: req=4'b1111 held, words 1000/0100/0010/0001 for requesters 0..3 -> grants in order 0,1,2,3,0; sel_id tracks each; every frame is 4 valid bits separated by exactly 2 invalid cycles.
- Wrap-around: grant requester 3 first (req=1000 only), then req=0101 -> next grant is requester 0, then requester 2.
- Late and dropped requests: req1 asserted mid-SHIFT of req0's frame -> no gnt until after done + GAP. Drop req2 before IDLE -> requester 2 is never granted and the pointer is unchanged.
- Reset mid-frame: assert rst after 2 bits of 1011 -> sout=0, sout_valid=0, busy=0, no done. After release, req=0010 is granted first as requester 1 from ptr=0.
- GAP=0 build: back-to-back requests -> exactly 1 invalid cycle between frames; done coincides with the IDLE cycle.
